imem_bootload: RTL and testbench
================================

# imem_bootload

Parametrised instruction memory for the 12-bit CPU family, replacing hard-coded reset-time program images with a byte-serial boot loader. After reset it zero-sweeps the array (all words become HALT), then accepts a length-prefixed program image over a ready/valid byte port. It serves CPU fetches through a registered read port and asserts BUSY so the core stalls while the array is being written.

## Interface
- DATA_W, 16, instruction width in bits; must be a multiple of 8.
- ADDR_W, 8, byte-address width of the fetch port.
- DEPTH, 128, number of words; must be ≤ 2^(ADDR_W − log2(DATA_W/8)).
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- FETCH_EN  in  1  fetch request.
- ADDR  in  ADDR_W  byte address; word index = ADDR >> log2(DATA_W/8).
- Q  out  DATA_W  fetched word, registered.
- Q_VALID  out  1  Q updated by a fetch accepted on the previous edge.
- MISALIGN  out  1  registered; the accepted fetch had nonzero low byte-offset bits.
- LD_START  in  1  begin load; sampled only in IDLE.
- LD_VALID  in  1  LD_DATA holds a byte.
- LD_DATA  in  8  image byte.
- LD_READY  out  1  block accepts a byte this cycle.
- LD_DONE  out  1  one-cycle pulse: load and zero-fill complete.
- LD_ERR  out  1  one-cycle pulse: header rejected.
- BUSY  out  1  array being written; fetches are blocked.

## Operation
- States: CLEAR, IDLE, HDR_HI, HDR_LO, DATA, FILL.
- Reset values: Q=0, Q_VALID=0, MISALIGN=0, LD_READY=0, LD_DONE=0, LD_ERR=0, BUSY=1, state=CLEAR, fill pointer=0.
- CLEAR: write 0 to word[ptr] each cycle, ptr 0..DEPTH−1, then go to IDLE. LD_DONE is not pulsed.
- IDLE: BUSY=0. LD_START=1 goes to HDR_HI. LD_START in any other state is ignored.
- A byte transfer occurs on an edge where LD_VALID & LD_READY. LD_READY=1 only in HDR_HI, HDR_LO and DATA.
- HDR_HI / HDR_LO: big-endian 16-bit word count N.
  - On the HDR_LO transfer, if N==0 or N>DEPTH: pulse LD_ERR, go to IDLE, and leave the array unmodified.
  - Otherwise go to DATA with word pointer 0.
- DATA: bytes are assembled MSB first, DATA_W/8 bytes per word.
  - The word is written to the array on the edge that accepts its last byte; the pointer then increments.
  - After word N−1: if N<DEPTH go to FILL starting at N; if N==DEPTH, pulse LD_DONE and go to IDLE.
- FILL: same as CLEAR, but starts at N. After word DEPTH−1, pulse LD_DONE and go to IDLE.
- BUSY=1 in every state except IDLE. BUSY is registered and follows the state register.
- Fetch: accepted when FETCH_EN & !BUSY.
  - Q <= word[index], or 0 if index ≥ DEPTH.
  - Q_VALID <= 1; MISALIGN <= (low offset bits ≠ 0).
  - A misaligned fetch still returns the truncated-index word.
- When no fetch is accepted: Q holds, Q_VALID <= 0, MISALIGN <= 0.
- RESET mid-load or mid-fill: abandon, return to CLEAR and redo the full sweep. Any partial word is discarded.

## Timing
- Fetch latency 1: address on edge k gives Q/Q_VALID valid after edge k; back-to-back fetches run at 1 word per cycle.
- CLEAR after RESET falls: DEPTH cycles. BUSY deasserts after the edge that writes word DEPTH−1.
- Load duration: 2 header transfers, then N·DATA_W/8 data transfers (gaps allowed while LD_VALID is low), then DEPTH−N FILL cycles.
- LD_DONE and LD_ERR are registered and high for exactly one cycle, coincident with the first IDLE cycle.
- LD_READY may stay high across consecutive transfers: 1 byte per cycle maximum.
- FETCH_EN on the same edge as LD_START in IDLE: the fetch is served; the state moves to HDR_HI.

## Test plan
- Reset, then hold for 128 cycles → BUSY high for 128 cycles; fetch of ADDR 0x00, 0x10 and 0xFE each returns Q=0x0000 with Q_VALID=1 one cycle later.
- Load N=3 with bytes 00 03 F0 01 20 79 50 80 (LD_VALID held high) → LD_DONE after 8 transfers + 125 fill cycles.
  - ADDR 0x00 → 0xF001, 0x02 → 0x2079, 0x04 → 0x5080, 0x06 → 0x0000.
- Header 00 81 (N=129, DEPTH=128) → LD_ERR pulse; previously loaded contents unchanged; BUSY low the next cycle.
- Fetch ADDR 0x03 after the load above → Q=0x2079, MISALIGN=1; FETCH_EN=1 while BUSY=1 → Q_VALID=0 and Q unchanged.
- Assert RESET after 5 data bytes of an N=4 load → full clear sweep (BUSY high for 128 cycles); all fetches return 0; no LD_DONE pulse.
- DATA_W=24, DEPTH=64 build: N=1 with bytes AB CD EF → ADDR 0x00 returns 0xABCDEF; ADDR 0x03 returns 0x000000.

Source files
------------

// File: rtl/imem_bootload.sv
// imem_bootload: instruction memory for the 12-bit CPU family, filled by a byte-serial boot loader.
// Latency: fetch data/valid registered 1 cycle after the accepting edge; loader takes 1 byte/cycle max.
// Backpressure: LD_READY only while expecting header/data bytes; fetches are refused while BUSY is high.
//
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   FETCH_EN, ADDR             fetch request and byte address (word index = ADDR / bytes-per-word)
//   Q, Q_VALID, MISALIGN       registered fetch result, valid strobe, nonzero byte-offset flag
//   LD_START                   begin a load (honoured only in IDLE)
//   LD_VALID, LD_DATA, LD_READY  ready/valid byte stream: 16-bit big-endian word count, then words MSB first
//   LD_DONE, LD_ERR            one-cycle pulses on the first IDLE cycle after a load / rejected header
//   BUSY                       array is being swept or loaded; the core must stall fetches
module imem_bootload #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 128
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FETCH_EN,
  input  logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Q,
  output logic              Q_VALID,
  output logic              MISALIGN,
  input  logic              LD_START,
  input  logic              LD_VALID,
  input  logic [7:0]        LD_DATA,
  output logic              LD_READY,
  output logic              LD_DONE,
  output logic              LD_ERR,
  output logic              BUSY
);

  localparam int BYTES = DATA_W / 8;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [BC_W-1:0]  LAST_BC  = BC_W'(BYTES - 1);

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    FILL
  } state_t;

  state_t            state_q;
  logic [PTR_W-1:0]  ptr_q;       // word pointer shared by sweep, data and fill
  logic [BC_W-1:0]   bcnt_q;      // byte position within the word being assembled
  logic [15:0]       n_q;         // word count from the header
  logic [DATA_W-1:0] asm_q;       // partially assembled word (earlier bytes)
  logic [DATA_W-1:0] q_q;
  logic              q_vld_q;
  logic              misalign_q;
  logic              ld_rdy_q;
  logic              ld_done_q;
  logic              ld_err_q;
  logic              busy_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Load-side decode
  logic              xfer;
  logic [DATA_W-1:0] asm_d;
  logic [15:0]       hdr_n;
  logic              hdr_bad;
  logic              word_last;
  logic              img_last;

  assign xfer      = LD_VALID & ld_rdy_q;
  // Shift the new byte in at the bottom; the cast drops the oldest byte so the
  // first byte received ends up in the MSBs once the word is complete.
  assign asm_d     = DATA_W'({asm_q, LD_DATA});
  assign hdr_n     = {n_q[15:8], LD_DATA};
  assign hdr_bad   = (hdr_n == 16'd0) || (32'(hdr_n) > DEPTH);
  assign word_last = (bcnt_q == LAST_BC);
  assign img_last  = (32'(ptr_q) == (32'(n_q) - 32'd1));

  // Fetch-side decode; division by a constant reduces to a shift for power-of-two widths
  logic [ADDR_W-1:0] f_idx;
  logic              f_off;
  logic              f_in;
  logic [PTR_W-1:0]  f_ptr;

  assign f_idx = ADDR_W'(32'(ADDR) / BYTES);
  assign f_off = ((32'(ADDR) % BYTES) != 0);
  assign f_in  = (32'(f_idx) < DEPTH);
  assign f_ptr = PTR_W'(f_idx);

  // Array write port: zero during sweep/fill, assembled word on the last data byte.
  // Nothing is written while RESET is high so a partial word is simply dropped.
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdat;

  always_comb begin
    mem_we   = 1'b0;
    mem_wdat = '0;
    if (!RESET) begin
      case (state_q)
        CLEAR, FILL: mem_we = 1'b1;
        DATA: begin
          if (xfer && word_last) begin
            mem_we   = 1'b1;
            mem_wdat = asm_d;
          end
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[ptr_q] <= mem_wdat;
    end
  end

  // Control FSM with registered outputs; BUSY/LD_READY are loaded with the
  // value matching the state being entered so they track state_q exactly.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= CLEAR;
      ptr_q      <= '0;
      bcnt_q     <= '0;
      n_q        <= '0;
      asm_q      <= '0;
      q_q        <= '0;
      q_vld_q    <= 1'b0;
      misalign_q <= 1'b0;
      ld_rdy_q   <= 1'b0;
      ld_done_q  <= 1'b0;
      ld_err_q   <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      ld_done_q <= 1'b0;
      ld_err_q  <= 1'b0;

      // Fetches only happen in IDLE, so they never race an array write.
      if (FETCH_EN && !busy_q) begin
        q_q        <= f_in ? mem_q[f_ptr] : '0;
        q_vld_q    <= 1'b1;
        misalign_q <= f_off;
      end else begin
        q_vld_q    <= 1'b0;
        misalign_q <= 1'b0;
      end

      case (state_q)
        CLEAR, FILL: begin
          if (ptr_q == LAST_PTR) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            ptr_q     <= '0;
            // Only a fill completes a load; the power-on sweep is silent.
            ld_done_q <= (state_q == FILL);
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end

        IDLE: begin
          if (LD_START) begin
            state_q  <= HDR_HI;
            busy_q   <= 1'b1;
            ld_rdy_q <= 1'b1;
          end
        end

        HDR_HI: begin
          if (xfer) begin
            n_q[15:8] <= LD_DATA;
            state_q   <= HDR_LO;
          end
        end

        HDR_LO: begin
          if (xfer) begin
            if (hdr_bad) begin
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              ld_rdy_q <= 1'b0;
              ld_err_q <= 1'b1;
            end else begin
              n_q     <= hdr_n;
              ptr_q   <= '0;
              bcnt_q  <= '0;
              state_q <= DATA;
            end
          end
        end

        DATA: begin
          if (xfer) begin
            if (word_last) begin
              bcnt_q <= '0;
              if (img_last) begin
                ld_rdy_q <= 1'b0;
                if (32'(n_q) == DEPTH) begin
                  // Image covers the whole array: nothing left to fill.
                  state_q   <= IDLE;
                  busy_q    <= 1'b0;
                  ptr_q     <= '0;
                  ld_done_q <= 1'b1;
                end else begin
                  state_q <= FILL;
                  ptr_q   <= ptr_q + 1'b1;
                end
              end else begin
                ptr_q <= ptr_q + 1'b1;
              end
            end else begin
              bcnt_q <= bcnt_q + 1'b1;
              asm_q  <= asm_d;
            end
          end
        end

        default: begin
          state_q  <= CLEAR;
          ptr_q    <= '0;
          busy_q   <= 1'b1;
          ld_rdy_q <= 1'b0;
        end
      endcase
    end
  end

  assign Q        = q_q;
  assign Q_VALID  = q_vld_q;
  assign MISALIGN = misalign_q;
  assign LD_READY = ld_rdy_q;
  assign LD_DONE  = ld_done_q;
  assign LD_ERR   = ld_err_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_imem_bootload.sv
// tb_imem_bootload: self-checking bench for imem_bootload (16-bit/128-word build plus a 24-bit/64-word build).
// Reference model is a plain word array updated from whole images; fetches are compared against it.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
`timescale 1ns/1ps
module tb_imem_bootload;
  localparam int DP = 128;
  localparam int BY = 2;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        FETCH_EN, Q_VALID, MISALIGN, LD_START, LD_VALID, LD_READY, LD_DONE, LD_ERR, BUSY;
  logic [7:0]  ADDR, LD_DATA;
  logic [15:0] Q;

  logic        w_fetch_en, w_q_valid, w_misalign, w_ld_start, w_ld_valid, w_ld_ready;
  logic        w_ld_done, w_ld_err, w_busy;
  logic [7:0]  w_addr, w_ld_data;
  logic [23:0] w_q;

  int checks = 0;
  int failures = 0;
  logic [15:0] model [DP];

  always #5 CLK = ~CLK;

  imem_bootload #(.DATA_W(16), .ADDR_W(8), .DEPTH(DP)) dut (
    .CLK(CLK), .RESET(RESET), .FETCH_EN(FETCH_EN), .ADDR(ADDR), .Q(Q), .Q_VALID(Q_VALID),
    .MISALIGN(MISALIGN), .LD_START(LD_START), .LD_VALID(LD_VALID), .LD_DATA(LD_DATA),
    .LD_READY(LD_READY), .LD_DONE(LD_DONE), .LD_ERR(LD_ERR), .BUSY(BUSY)
  );

  imem_bootload #(.DATA_W(24), .ADDR_W(8), .DEPTH(64)) dut_w (
    .CLK(CLK), .RESET(RESET), .FETCH_EN(w_fetch_en), .ADDR(w_addr), .Q(w_q), .Q_VALID(w_q_valid),
    .MISALIGN(w_misalign), .LD_START(w_ld_start), .LD_VALID(w_ld_valid), .LD_DATA(w_ld_data),
    .LD_READY(w_ld_ready), .LD_DONE(w_ld_done), .LD_ERR(w_ld_err), .BUSY(w_busy)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] exp_q(input logic [7:0] a);
    int idx = int'(a) / BY;
    return (idx < DP) ? model[idx] : 16'h0000;
  endfunction

  // Whole-image effect: valid header -> words 0..N-1 from the image, rest zero.
  function automatic void apply_image(input logic [7:0] b[$]);
    int n = int'({b[0], b[1]});
    if (n == 0 || n > DP) return;
    for (int w = 0; w < DP; w++)
      model[w] = (w < n) ? {b[2 + 2*w], b[3 + 2*w]} : 16'h0000;
  endfunction

  task automatic make_image(input int n, output logic [7:0] b[$]);
    b = {};
    b.push_back(8'(n >> 8));
    b.push_back(8'(n));
    if (n >= 1 && n <= DP)
      for (int i = 0; i < n * BY; i++) b.push_back(8'($urandom));
  endtask

  // Drives one image; post = cycles from the last byte transfer to LD_DONE/LD_ERR.
  task automatic run_load(input logic [7:0] b[$], input bit start, input int gap_max,
                          output int post, output bit done, output bit err, output bit tmo);
    int guard;
    tmo = 0; done = 0; err = 0; post = -1;
    if (start) begin
      LD_START = 1; step(); LD_START = 0;
    end
    foreach (b[i]) begin
      repeat ($urandom_range(gap_max, 0)) step();
      LD_VALID = 1; LD_DATA = b[i]; guard = 0;
      while (LD_READY !== 1'b1 && guard < 50) begin step(); guard++; end
      if (LD_READY !== 1'b1) begin LD_VALID = 0; tmo = 1; return; end
      step();
      LD_VALID = 0;
    end
    post = 0;
    while (LD_DONE !== 1'b1 && LD_ERR !== 1'b1 && post < 2000) begin step(); post++; end
    done = (LD_DONE === 1'b1);
    err  = (LD_ERR === 1'b1);
    if (!done && !err) tmo = 1;
  endtask

  task automatic test_back_to_back(input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = 8'($urandom);
      FETCH_EN = 1; ADDR = a; step();
      checks++;
      if (Q_VALID !== 1'b1 || Q !== exp_q(a) || MISALIGN !== ((int'(a) % BY) != 0)) begin
        failures++;
        $display("FAIL fetch_b2b addr=%02h: got q=%04h v=%b m=%b, expected q=%04h v=1 m=%0d",
                 a, Q, Q_VALID, MISALIGN, exp_q(a), (int'(a) % BY) != 0);
      end
    end
    FETCH_EN = 0; step();
    checks++;
    if (Q_VALID !== 1'b0 || MISALIGN !== 1'b0 || Q !== exp_q(a)) begin
      failures++;
      $display("FAIL fetch_idle_hold: got q=%04h v=%b m=%b, expected q=%04h v=0 m=0", Q, Q_VALID, MISALIGN, exp_q(a));
    end
  endtask

  task automatic test_reset();
    int cnt;
    bit leak;
    RESET = 1; FETCH_EN = 0; ADDR = 0; LD_START = 0; LD_VALID = 0; LD_DATA = 0;
    w_fetch_en = 0; w_addr = 0; w_ld_start = 0; w_ld_valid = 0; w_ld_data = 0;
    repeat (3) step();
    checks++;
    if ({BUSY, Q_VALID, MISALIGN, LD_READY, LD_DONE, LD_ERR, Q} !== {1'b1, 5'b0, 16'h0000}) begin
      failures++;
      $display("FAIL reset_state: got busy=%b v=%b m=%b rdy=%b done=%b err=%b q=%04h, expected 1 0 0 0 0 0 0000",
               BUSY, Q_VALID, MISALIGN, LD_READY, LD_DONE, LD_ERR, Q);
    end
    RESET = 0; FETCH_EN = 1; ADDR = 8'h10; cnt = 0; leak = 0;
    while (BUSY === 1'b1 && cnt < 1000) begin
      step(); cnt++;
      if (Q_VALID !== 1'b0 || LD_DONE !== 1'b0 || LD_READY !== 1'b0) leak = 1;
    end
    FETCH_EN = 0;
    checks++;
    if (cnt != DP) begin failures++; $display("FAIL clear_len: got %0d busy cycles, expected %0d", cnt, DP); end
    checks++;
    if (leak) begin failures++; $display("FAIL clear_quiet: got valid/done/ready during sweep, expected none"); end
    foreach (model[i]) model[i] = 16'h0000;
  endtask

  task automatic test_fetch_zero();
    logic [7:0] at[3] = '{8'h00, 8'h10, 8'hFE};
    foreach (at[i]) begin
      FETCH_EN = 1; ADDR = at[i]; step();
      checks++;
      if (Q_VALID !== 1'b1 || Q !== 16'h0000 || MISALIGN !== 1'b0) begin
        failures++;
        $display("FAIL fetch_zero addr=%02h: got q=%04h v=%b m=%b, expected q=0000 v=1 m=0", at[i], Q, Q_VALID, MISALIGN);
      end
    end
    FETCH_EN = 0; step();
    checks++;
    if (Q_VALID !== 1'b0) begin failures++; $display("FAIL fetch_zero_idle: got v=%b, expected 0", Q_VALID); end
  endtask

  task automatic test_load_example();
    logic [7:0]  img[$];
    logic [15:0] expv[4] = '{16'hF001, 16'h2079, 16'h5080, 16'h0000};
    int post; bit done, err, tmo;
    img = {8'h00, 8'h03, 8'hF0, 8'h01, 8'h20, 8'h79, 8'h50, 8'h80};
    run_load(img, 1'b1, 0, post, done, err, tmo);
    checks++;
    if (tmo || !done || err || post != DP - 3) begin
      failures++;
      $display("FAIL load_n3: got done=%0d err=%0d tmo=%0d fill=%0d, expected done=1 err=0 tmo=0 fill=%0d",
               done, err, tmo, post, DP - 3);
    end
    step();
    checks++;
    if (LD_DONE !== 1'b0 || BUSY !== 1'b0) begin
      failures++; $display("FAIL done_pulse: got done=%b busy=%b, expected 0 0", LD_DONE, BUSY);
    end
    apply_image(img);
    for (int i = 0; i < 4; i++) begin
      FETCH_EN = 1; ADDR = 8'(2 * i); step();
      checks++;
      if (Q !== expv[i] || Q_VALID !== 1'b1) begin
        failures++; $display("FAIL load_n3_word%0d: got q=%04h v=%b, expected q=%04h v=1", i, Q, Q_VALID, expv[i]);
      end
    end
    FETCH_EN = 0; step();
  endtask

  task automatic test_err();
    logic [7:0] img[$];
    int post; bit done, err, tmo;
    img = {8'h00, 8'h81};
    run_load(img, 1'b1, 0, post, done, err, tmo);
    checks++;
    if (tmo || !err || done || post != 0 || BUSY !== 1'b0 || LD_READY !== 1'b0) begin
      failures++;
      $display("FAIL hdr_err_129: got err=%0d done=%0d tmo=%0d post=%0d busy=%b rdy=%b, expected 1 0 0 0 0 0",
               err, done, tmo, post, BUSY, LD_READY);
    end
    step();
    checks++;
    if (LD_ERR !== 1'b0) begin failures++; $display("FAIL err_pulse: got err=%b, expected 0", LD_ERR); end
    img = {8'h00, 8'h00};
    run_load(img, 1'b1, 1, post, done, err, tmo);
    checks++;
    if (tmo || !err || done || post != 0) begin
      failures++; $display("FAIL hdr_err_0: got err=%0d done=%0d tmo=%0d post=%0d, expected 1 0 0 0", err, done, tmo, post);
    end
    step();
    test_back_to_back(16);
  endtask

  task automatic test_misalign_busy();
    logic [7:0] img[$];
    int post; bit done, err, tmo;
    FETCH_EN = 1; ADDR = 8'h03; step();
    checks++;
    if (Q !== 16'h2079 || MISALIGN !== 1'b1 || Q_VALID !== 1'b1) begin
      failures++; $display("FAIL misalign: got q=%04h m=%b v=%b, expected q=2079 m=1 v=1", Q, MISALIGN, Q_VALID);
    end
    ADDR = 8'h04; LD_START = 1; step(); LD_START = 0;
    checks++;
    if (Q !== 16'h5080 || Q_VALID !== 1'b1 || BUSY !== 1'b1 || LD_READY !== 1'b1) begin
      failures++;
      $display("FAIL fetch_with_start: got q=%04h v=%b busy=%b rdy=%b, expected q=5080 v=1 busy=1 rdy=1",
               Q, Q_VALID, BUSY, LD_READY);
    end
    ADDR = 8'h00; step(); FETCH_EN = 0;
    checks++;
    if (Q_VALID !== 1'b0 || Q !== 16'h5080 || MISALIGN !== 1'b0) begin
      failures++; $display("FAIL fetch_blocked: got q=%04h v=%b m=%b, expected q=5080 v=0 m=0", Q, Q_VALID, MISALIGN);
    end
    make_image(DP, img);
    run_load(img, 1'b0, 1, post, done, err, tmo);
    checks++;
    if (tmo || !done || err || post != 0) begin
      failures++; $display("FAIL load_full: got done=%0d err=%0d tmo=%0d post=%0d, expected 1 0 0 0", done, err, tmo, post);
    end
    apply_image(img);
    step();
    test_back_to_back(32);
  endtask

  task automatic test_random_loads();
    logic [7:0] img[$];
    int n, post; bit done, err, tmo;
    for (int it = 0; it < 6; it++) begin
      case (it)
        0:       n = 1;
        1:       n = DP - 1;
        2:       n = $urandom_range(DP - 2, 2);
        3:       n = $urandom_range(65535, DP + 1);
        default: n = $urandom_range(DP, 1);
      endcase
      make_image(n, img);
      run_load(img, 1'b1, 2, post, done, err, tmo);
      checks++;
      if (n >= 1 && n <= DP) begin
        if (tmo || !done || err || post != DP - n) begin
          failures++;
          $display("FAIL rand_load n=%0d: got done=%0d err=%0d tmo=%0d fill=%0d, expected 1 0 0 %0d",
                   n, done, err, tmo, post, DP - n);
        end
      end else begin
        if (tmo || !err || done || post != 0) begin
          failures++;
          $display("FAIL rand_badhdr n=%0d: got err=%0d done=%0d tmo=%0d post=%0d, expected 1 0 0 0", n, err, done, tmo, post);
        end
      end
      apply_image(img);
      step();
      test_back_to_back(40);
    end
  endtask

  task automatic test_reset_midload();
    logic [7:0] img[$];
    int cnt;
    bit leak;
    img = {8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    LD_START = 1; step(); LD_START = 0;
    foreach (img[i]) begin LD_VALID = 1; LD_DATA = img[i]; step(); end
    LD_VALID = 0;
    checks++;
    if (LD_READY !== 1'b1 || BUSY !== 1'b1) begin
      failures++; $display("FAIL midload_state: got rdy=%b busy=%b, expected 1 1", LD_READY, BUSY);
    end
    RESET = 1; step(); RESET = 0;
    cnt = 0; leak = 0;
    while (BUSY === 1'b1 && cnt < 1000) begin
      step(); cnt++;
      if (LD_DONE !== 1'b0 || LD_ERR !== 1'b0 || LD_READY !== 1'b0) leak = 1;
    end
    checks++;
    if (cnt != DP || leak) begin
      failures++; $display("FAIL reset_midload: got %0d busy cycles leak=%0d, expected %0d leak=0", cnt, leak, DP);
    end
    foreach (model[i]) model[i] = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      FETCH_EN = 1; ADDR = 8'(2 * i); step();
      checks++;
      if (Q !== 16'h0000 || Q_VALID !== 1'b1) begin
        failures++; $display("FAIL reset_midload_word%0d: got q=%04h v=%b, expected q=0000 v=1", i, Q, Q_VALID);
      end
    end
    FETCH_EN = 0; step();
    test_back_to_back(24);
  endtask

  task automatic test_wide();
    logic [7:0] wb[5] = '{8'h00, 8'h01, 8'hAB, 8'hCD, 8'hEF};
    int cnt;
    checks++;
    if (w_busy !== 1'b0) begin failures++; $display("FAIL wide_idle: got busy=%b, expected 0", w_busy); end
    w_ld_start = 1; step(); w_ld_start = 0;
    foreach (wb[i]) begin
      w_ld_valid = 1; w_ld_data = wb[i]; cnt = 0;
      while (w_ld_ready !== 1'b1 && cnt < 20) begin step(); cnt++; end
      step();
    end
    w_ld_valid = 0; cnt = 0;
    while (w_ld_done !== 1'b1 && cnt < 500) begin step(); cnt++; end
    checks++;
    if (w_ld_done !== 1'b1 || cnt != 63) begin
      failures++; $display("FAIL wide_load: got done=%b fill=%0d, expected done=1 fill=63", w_ld_done, cnt);
    end
    w_fetch_en = 1; w_addr = 8'h00; step();
    checks++;
    if (w_q !== 24'hABCDEF || w_q_valid !== 1'b1) begin
      failures++; $display("FAIL wide_word0: got q=%06h v=%b, expected q=abcdef v=1", w_q, w_q_valid);
    end
    w_addr = 8'h03; step(); w_fetch_en = 0;
    checks++;
    if (w_q !== 24'h000000 || w_q_valid !== 1'b1) begin
      failures++; $display("FAIL wide_word1: got q=%06h v=%b, expected q=000000 v=1", w_q, w_q_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_zero();
    test_load_example();
    test_err();
    test_misalign_busy();
    test_random_loads();
    test_reset_midload();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
